// File: rtl/dbg_uart_pkg.sv
// dbg_uart_pkg: shared constants and state encodings for the debug UART to
// Wishbone bridge.
//   CMD_RD / CMD_WR   command bytes accepted from the host
//   RSP_WR_OK         reply byte for a completed write
//   RSP_ERR           reply byte for a Wishbone timeout
//   dbg_state_e       command FSM states
//   rx_state_e        UART receiver states
//   tx_state_e        UART transmitter states
package dbg_uart_pkg;

   localparam logic [7:0] CMD_RD    = 8'hA1;
   localparam logic [7:0] CMD_WR    = 8'hA2;
   localparam logic [7:0] RSP_WR_OK = 8'hAC;
   localparam logic [7:0] RSP_ERR   = 8'hEE;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StWdata,
      StWb,
      StResp
   } dbg_state_e;

   typedef enum logic [1:0] {
      RxIdle,
      RxStart,
      RxData,
      RxStop
   } rx_state_e;

   typedef enum logic {
      TxIdle,
      TxBusy
   } tx_state_e;

endpackage

// File: rtl/dbg_uart_phy.sv
// dbg_uart_phy: 8N1 UART receiver and transmitter, LSB first.
//   clk, rst          clock, synchronous active-high reset
//   ser_rx            asynchronous serial input (2-flop synchronised here)
//   ser_tx            serial output, idles high
//   rx_valid/rx_data  one-cycle pulse with a received byte (stop bit was 1)
//   rx_err            one-cycle pulse when a byte had a 0 stop bit (byte dropped)
//   tx_start/tx_data  load a byte for transmission (honoured only while idle)
//   tx_busy           high while a byte (start, data, stop) is being sent
module dbg_uart_phy
   import dbg_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 87
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ser_rx,
   output logic       ser_tx,
   output logic       rx_valid,
   output logic       rx_err,
   output logic [7:0] rx_data,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

   // Receiver
   rx_state_e     rx_state;
   logic          rx_meta, rx_sync, rx_prev;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= RxIdle;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         rx_data  <= '0;
      end else begin
         rx_meta  <= ser_rx;
         rx_sync  <= rx_meta;
         rx_prev  <= rx_sync;
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         unique case (rx_state)
            RxIdle: begin
               if (rx_prev && !rx_sync) begin
                  rx_state <= RxStart;
                  rx_cnt   <= '0;
               end
            end
            RxStart: begin
               // Line back high at mid start bit: a glitch, not a frame.
               if (rx_cnt == HALF) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_sync ? RxIdle : RxData;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RxData: begin
               if (rx_cnt == FULL) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_sync, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 3'd1;
                  if (rx_bit == 3'd7) rx_state <= RxStop;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RxStop: begin
               if (rx_cnt == FULL) begin
                  rx_cnt   <= '0;
                  rx_state <= RxIdle;
                  if (rx_sync) begin
                     rx_valid <= 1'b1;
                     rx_data  <= rx_shift;
                  end else begin
                     rx_err <= 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: rx_state <= RxIdle;
         endcase
      end
   end

   // Transmitter: start bit driven on load, then 8 data bits and the stop bit
   // shifted out of tx_shift (stop bit pre-loaded in its MSB).
   tx_state_e     tx_state;
   logic [CW-1:0] tx_cnt;
   logic [3:0]    tx_bit;
   logic [8:0]    tx_shift;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= TxIdle;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '1;
         ser_tx   <= 1'b1;
      end else begin
         unique case (tx_state)
            TxIdle: begin
               ser_tx <= 1'b1;
               if (tx_start) begin
                  tx_state <= TxBusy;
                  tx_shift <= {1'b1, tx_data};
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  ser_tx   <= 1'b0;
               end
            end
            TxBusy: begin
               if (tx_cnt == FULL) begin
                  tx_cnt <= '0;
                  if (tx_bit == 4'd9) begin
                     tx_state <= TxIdle;
                     ser_tx   <= 1'b1;
                  end else begin
                     ser_tx   <= tx_shift[0];
                     tx_shift <= {1'b1, tx_shift[8:1]};
                     tx_bit   <= tx_bit + 4'd1;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: tx_state <= TxIdle;
         endcase
      end
   end

   assign tx_busy = (tx_state == TxBusy);

endmodule

// File: rtl/dbg_uart_wb_bridge.sv
// dbg_uart_wb_bridge: debug responder that turns UART command frames into
// single 32-bit Wishbone master cycles and replies over UART.
//   Frame: CMD (A1 read / A2 write), A3..A0, [D3..D0 for writes], MSB first.
//   Reply: read -> D3..D0, write -> AC; on timeout EE (x4 for reads).
// Ports:
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   dbg_en               strap enable (already synchronised)
//   ser_rx, ser_tx       UART pads (ser_tx idles high)
//   wbm_*                Wishbone master (sel is 4'hF during a cycle)
//   busy_o               high whenever the command FSM is not idle
// Build option: define DBG_WB_TIMEOUT_EN to bound the ack wait to TIMEOUT_CYC
// cycles; otherwise the bridge waits for ack indefinitely.
module dbg_uart_wb_bridge
   import dbg_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 87,
   parameter int unsigned TIMEOUT_CYC  = 1024
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        dbg_en,
   input  logic        ser_rx,
   output logic        ser_tx,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic        busy_o
);

   logic       rx_valid, rx_err, tx_busy;
   logic [7:0] rx_data;
   logic       tx_start;
   logic [7:0] tx_data;

   dbg_uart_phy #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_phy (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .ser_rx  (ser_rx),
      .ser_tx  (ser_tx),
      .rx_valid(rx_valid),
      .rx_err  (rx_err),
      .rx_data (rx_data),
      .tx_start(tx_start),
      .tx_data (tx_data),
      .tx_busy (tx_busy)
   );

   logic wb_timeout;

`ifdef DBG_WB_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] to_cnt;

   // Counts cycles with cyc high; expires on the TIMEOUT_CYC-th cycle.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || !wbm_cyc_o) to_cnt <= '0;
      else                        to_cnt <= to_cnt + 1'b1;
   end

   assign wb_timeout = wbm_cyc_o && (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYC;
   assign wb_timeout = 1'b0;
`endif

   dbg_state_e  state;
   logic        is_wr;
   logic [1:0]  byte_cnt;
   logic [31:0] resp_buf;
   logic [2:0]  resp_left;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= StIdle;
         is_wr     <= 1'b0;
         byte_cnt  <= '0;
         resp_buf  <= '0;
         resp_left <= '0;
         tx_start  <= 1'b0;
         tx_data   <= '0;
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= '0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (dbg_en && rx_valid && (rx_data == CMD_RD || rx_data == CMD_WR)) begin
                  state    <= StAddr;
                  is_wr    <= (rx_data == CMD_WR);
                  byte_cnt <= '0;
               end
            end
            StAddr: begin
               if (!dbg_en || rx_err) begin
                  state <= StIdle;
               end else if (rx_valid) begin
                  wbm_adr_o <= {wbm_adr_o[23:0], rx_data};
                  byte_cnt  <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     if (is_wr) begin
                        state <= StWdata;
                     end else begin
                        state     <= StWb;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= 4'hF;
                     end
                  end
               end
            end
            StWdata: begin
               if (!dbg_en || rx_err) begin
                  state <= StIdle;
               end else if (rx_valid) begin
                  wbm_dat_o <= {wbm_dat_o[23:0], rx_data};
                  byte_cnt  <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     state     <= StWb;
                     wbm_cyc_o <= 1'b1;
                     wbm_stb_o <= 1'b1;
                     wbm_we_o  <= 1'b1;
                     wbm_sel_o <= 4'hF;
                  end
               end
            end
            StWb: begin
               // dbg_en is ignored here: a started bus cycle always completes.
               if (wbm_ack_i) begin
                  resp_buf  <= is_wr ? {RSP_WR_OK, 24'h0} : wbm_dat_i;
                  resp_left <= is_wr ? 3'd1 : 3'd4;
               end else if (wb_timeout) begin
                  resp_buf  <= {4{RSP_ERR}};
                  resp_left <= is_wr ? 3'd1 : 3'd4;
               end
               if (wbm_ack_i || wb_timeout) begin
                  state     <= StResp;
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  wbm_we_o  <= 1'b0;
                  wbm_sel_o <= '0;
               end
            end
            StResp: begin
               // tx_start is a one-cycle pulse; the PHY is busy by the cycle after.
               if (tx_start) begin
                  tx_start <= 1'b0;
               end else if (!tx_busy) begin
                  if (resp_left == 3'd0 || !dbg_en) begin
                     state <= StIdle;
                  end else begin
                     tx_start  <= 1'b1;
                     tx_data   <= resp_buf[31:24];
                     resp_buf  <= {resp_buf[23:0], 8'h00};
                     resp_left <= resp_left - 3'd1;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign busy_o = (state != StIdle);

endmodule

// File: tb/tb_dbg_uart_wb_bridge.sv
// Directed bench for dbg_uart_wb_bridge: drives UART frames into ser_rx,
// models a Wishbone slave with a fixed ack delay, and decodes ser_tx.
module tb_dbg_uart_wb_bridge;

   localparam int unsigned CPB = 16;
   localparam int unsigned TO  = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dbg_en = 1'b1;
   logic        ser_rx = 1'b1;
   logic        ser_tx;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
   logic        wbm_ack_i;
   logic        busy_o;

   always #5 clk = ~clk;

   dbg_uart_wb_bridge #(
      .CLKS_PER_BIT(CPB),
      .TIMEOUT_CYC (TO)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .dbg_en   (dbg_en),
      .ser_rx   (ser_rx),
      .ser_tx   (ser_tx),
      .wbm_cyc_o(wbm_cyc_o),
      .wbm_stb_o(wbm_stb_o),
      .wbm_we_o (wbm_we_o),
      .wbm_sel_o(wbm_sel_o),
      .wbm_adr_o(wbm_adr_o),
      .wbm_dat_o(wbm_dat_o),
      .wbm_dat_i(wbm_dat_i),
      .wbm_ack_i(wbm_ack_i),
      .busy_o   (busy_o)
   );

   int checks = 0;
   int errors = 0;

   // Wishbone slave: acks after ack_delay+1 cycles of cyc&stb when enabled.
   logic        ack_en = 1'b1;
   int          ack_delay = 2;
   logic [31:0] rd_val = 32'h0;
   int          wait_cnt = 0;
   logic        slv_ack = 1'b0;

   assign wbm_ack_i = slv_ack;
   assign wbm_dat_i = slv_ack ? rd_val : 32'hBAD0_BAD0;

   always @(posedge clk) begin
      slv_ack <= 1'b0;
      if (wbm_cyc_o && wbm_stb_o && !slv_ack && ack_en) begin
         if (wait_cnt >= ack_delay) begin
            slv_ack  <= 1'b1;
            wait_cnt <= 0;
         end else begin
            wait_cnt <= wait_cnt + 1;
         end
      end else if (!wbm_cyc_o) begin
         wait_cnt <= 0;
      end
   end

   // Bus monitor: count cycle starts, capture the acked transfer.
   int          wb_starts = 0;
   logic        prev_cyc = 1'b0;
   logic [31:0] cap_adr = '0, cap_dat = '0;
   logic        cap_we = 1'b0;
   logic [3:0]  cap_sel = '0;

   always @(posedge clk) begin
      prev_cyc <= wbm_cyc_o;
      if (wbm_cyc_o && !prev_cyc) wb_starts <= wb_starts + 1;
      if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
         cap_adr <= wbm_adr_o;
         cap_dat <= wbm_dat_o;
         cap_we  <= wbm_we_o;
         cap_sel <= wbm_sel_o;
      end
   end

   // ser_tx decoder.
   logic [7:0] txq[$];

   initial begin
      wait (rst == 1'b0);
      forever begin
         logic [7:0] b;
         @(negedge ser_tx);
         repeat (CPB / 2) @(posedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            b[i] = ser_tx;
         end
         repeat (CPB) @(posedge clk);
         txq.push_back(b);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clk);
      ser_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         ser_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      ser_rx = stop;
      repeat (CPB) @(negedge clk);
      ser_rx = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
   endtask

   task automatic wait_txq(input int n, input int max_cyc);
      int c = 0;
      while (txq.size() < n && c < max_cyc) begin
         @(negedge clk);
         c++;
      end
      check("tx_reply_arrived", 32'(txq.size() >= n), 32'd1);
   endtask

   task automatic wait_idle(input int max_cyc);
      int c = 0;
      while (busy_o && c < max_cyc) begin
         @(negedge clk);
         c++;
      end
      check("busy_returns_low", 32'(busy_o), 32'd0);
   endtask

   task automatic wait_cyc(input int max_cyc);
      int c = 0;
      while (!wbm_cyc_o && c < max_cyc) begin
         @(negedge clk);
         c++;
      end
      check("cyc_asserted", 32'(wbm_cyc_o), 32'd1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_ser_tx", 32'(ser_tx), 32'd1);
      check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
      check("rst_stb", 32'(wbm_stb_o), 32'd0);
      check("rst_we", 32'(wbm_we_o), 32'd0);
      check("rst_sel", 32'(wbm_sel_o), 32'd0);
      check("rst_adr", wbm_adr_o, 32'd0);
      check("rst_dat", wbm_dat_o, 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1: write DEADBEEF to 3000_0004, expect AC.
      txq.delete();
      send_byte(8'hA2, 1'b1);
      send_word(32'h3000_0004);
      send_word(32'hDEAD_BEEF);
      wait_txq(1, 3000);
      wait_idle(3000);
      check("wr_starts", 32'(wb_starts), 32'd1);
      check("wr_adr", cap_adr, 32'h3000_0004);
      check("wr_dat", cap_dat, 32'hDEAD_BEEF);
      check("wr_we", 32'(cap_we), 32'd1);
      check("wr_sel", 32'(cap_sel), 32'hF);
      check("wr_reply", 32'(txq[0]), 32'hAC);
      check("wr_reply_count", 32'(txq.size()), 32'd1);
      check("wr_cyc_dropped", 32'(wbm_cyc_o), 32'd0);

      // 2: read 3000_0004 returning 1234_5678.
      rd_val = 32'h1234_5678;
      txq.delete();
      send_byte(8'hA1, 1'b1);
      send_word(32'h3000_0004);
      wait_txq(4, 4000);
      wait_idle(3000);
      check("rd_starts", 32'(wb_starts), 32'd2);
      check("rd_we", 32'(cap_we), 32'd0);
      check("rd_adr", cap_adr, 32'h3000_0004);
      check("rd_sel", 32'(cap_sel), 32'hF);
      check("rd_reply", {txq[0], txq[1], txq[2], txq[3]}, 32'h1234_5678);
      check("rd_ser_tx_idle", 32'(ser_tx), 32'd1);

      // 3: unknown command byte is ignored, following read completes.
      txq.delete();
      send_byte(8'h55, 1'b1);
      check("junk_busy", 32'(busy_o), 32'd0);
      check("junk_starts", 32'(wb_starts), 32'd2);
      rd_val = 32'hCAFE_F00D;
      send_byte(8'hA1, 1'b1);
      send_word(32'h3000_0010);
      wait_txq(4, 4000);
      wait_idle(3000);
      check("junk_rd_starts", 32'(wb_starts), 32'd3);
      check("junk_rd_adr", cap_adr, 32'h3000_0010);
      check("junk_rd_reply", {txq[0], txq[1], txq[2], txq[3]}, 32'hCAFE_F00D);

      // 4: framing error in the address drops the frame.
      txq.delete();
      send_byte(8'hA1, 1'b1);
      send_byte(8'h30, 1'b1);
      send_byte(8'h00, 1'b0);
      check("ferr_busy", 32'(busy_o), 32'd0);
      send_byte(8'h00, 1'b1);
      send_byte(8'h04, 1'b1);
      repeat (4 * CPB) @(negedge clk);
      check("ferr_starts", 32'(wb_starts), 32'd3);
      check("ferr_no_reply", 32'(txq.size()), 32'd0);
      send_byte(8'hA2, 1'b1);
      send_word(32'h3000_0020);
      send_word(32'h0102_0304);
      wait_txq(1, 3000);
      wait_idle(3000);
      check("ferr_next_starts", 32'(wb_starts), 32'd4);
      check("ferr_next_adr", cap_adr, 32'h3000_0020);
      check("ferr_next_dat", cap_dat, 32'h0102_0304);
      check("ferr_next_reply", 32'(txq[0]), 32'hAC);

      // 5a: dbg_en drop mid-address.
      txq.delete();
      send_byte(8'hA1, 1'b1);
      send_byte(8'h30, 1'b1);
      send_byte(8'h00, 1'b1);
      check("en_busy_before", 32'(busy_o), 32'd1);
      dbg_en = 1'b0;
      repeat (2) @(negedge clk);
      check("en_busy_after", 32'(busy_o), 32'd0);
      send_byte(8'h00, 1'b1);
      send_byte(8'h04, 1'b1);
      dbg_en = 1'b1;
      repeat (10 * CPB) @(negedge clk);
      check("en_starts", 32'(wb_starts), 32'd4);
      check("en_ser_tx", 32'(ser_tx), 32'd1);

      // 5b: reset during a bus cycle drops cyc without ack.
      ack_en = 1'b0;
      send_byte(8'hA1, 1'b1);
      send_word(32'h3000_0040);
      wait_cyc(2000);
      check("rstwb_busy", 32'(busy_o), 32'd1);
      check("rstwb_adr", wbm_adr_o, 32'h3000_0040);
      rst = 1'b1;
      @(negedge clk);
      check("rstwb_cyc", 32'(wbm_cyc_o), 32'd0);
      check("rstwb_stb", 32'(wbm_stb_o), 32'd0);
      check("rstwb_ser_tx", 32'(ser_tx), 32'd1);
      check("rstwb_busy_low", 32'(busy_o), 32'd0);
      check("rstwb_adr_clr", wbm_adr_o, 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // 6: slave never acks.
      txq.delete();
      send_byte(8'hA1, 1'b1);
      send_word(32'h3000_0080);
      wait_cyc(2000);
      repeat (TO - 50) @(negedge clk);
      check("to_cyc_held", 32'(wbm_cyc_o), 32'd1);
      repeat (100) @(negedge clk);
`ifdef DBG_WB_TIMEOUT_EN
      check("to_cyc_dropped", 32'(wbm_cyc_o), 32'd0);
      wait_txq(4, 4000);
      wait_idle(3000);
      check("to_reply", {txq[0], txq[1], txq[2], txq[3]}, 32'hEEEE_EEEE);
`else
      check("to_cyc_forever", 32'(wbm_cyc_o), 32'd1);
      check("to_busy", 32'(busy_o), 32'd1);
      check("to_no_reply", 32'(txq.size()), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("to_rst_cyc", 32'(wbm_cyc_o), 32'd0);
`endif
      ack_en = 1'b1;
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
